// File: rtl/ccff_chain_loader.sv
// ccff_chain_loader
// Streams a bitstream into a serial configuration flip-flop chain, one bit per
// prog_clk, and returns the displaced chain contents as readback words.
// Words arrive on bs_*, are shifted out LSB first on ccff_head, and the bits
// falling out of ccff_tail are packed into rd_data (first bit in bit 0).
module ccff_chain_loader #(
    parameter int CHAIN_LEN = 66,
    parameter int WORD_W    = 8
) (
    input  logic              prog_clk,
    input  logic              prog_reset,
    input  logic              start,
    input  logic              bs_valid,
    output logic              bs_ready,
    input  logic [WORD_W-1:0] bs_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [WORD_W-1:0] rd_data,
    output logic              ccff_head,
    input  logic              ccff_tail,
    output logic              ccff_shift_en,
    output logic              busy,
    output logic              cfg_done
);

    localparam int CNT_W = $clog2(CHAIN_LEN + 1);
    localparam int IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        SHIFT,
        DRAIN,
        DONE
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  bit_cnt;    // bits shifted so far in this load
    logic [IDX_W-1:0]  bit_idx;    // bit position within the current word
    logic [WORD_W-1:0] shift_reg;
    logic [WORD_W-1:0] rd_reg;
    logic              last_bit;

    // Final bit of a word: either the word is full or the chain is about to be full.
    always_comb begin
        last_bit = (bit_idx == IDX_W'(WORD_W - 1)) || (bit_cnt == CNT_W'(CHAIN_LEN - 1));
    end

    // State register with synchronous active-low reset.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge prog_clk) begin
        if (!prog_reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode.
    // NOTE: state_nxt gets a default before the case so no latch is inferred.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: if (start)    state_nxt = FETCH;
            FETCH:      if (bs_valid) state_nxt = SHIFT;
            SHIFT:      if (last_bit) state_nxt = DRAIN;
            DRAIN: begin
                if (rd_ready) begin
                    state_nxt = (bit_cnt == CNT_W'(CHAIN_LEN)) ? DONE : FETCH;
                end
            end
            default:    state_nxt = IDLE;
        endcase
    end

    // Datapath: word latch, serialiser, readback packing and bit counters.
    // NOTE: shift_reg and rd_reg are reset too, so rd_data reads 0 straight after reset.
    always_ff @(posedge prog_clk) begin
        if (!prog_reset) begin
            bit_cnt   <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
            rd_reg    <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) bit_cnt <= '0;
                end
                FETCH: begin
                    if (bs_valid) begin
                        shift_reg <= bs_data;
                        // Cleared per word so unused upper bits of a short final word read 0.
                        rd_reg    <= '0;
                        bit_idx   <= '0;
                    end
                end
                SHIFT: begin
                    shift_reg <= shift_reg >> 1;
                    for (int i = 0; i < WORD_W; i++) begin
                        if (bit_idx == IDX_W'(i)) rd_reg[i] <= ccff_tail;
                    end
                    bit_cnt <= bit_cnt + 1'b1;
                    bit_idx <= bit_idx + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Moore outputs decoded from the current state.
    always_comb begin
        bs_ready      = 1'b0;
        rd_valid      = 1'b0;
        ccff_shift_en = 1'b0;
        ccff_head     = 1'b0;
        busy          = 1'b1;
        cfg_done      = 1'b0;
        case (state)
            IDLE:  busy = 1'b0;
            FETCH: bs_ready = 1'b1;
            SHIFT: begin
                ccff_shift_en = 1'b1;
                ccff_head     = shift_reg[0];
            end
            DRAIN: rd_valid = 1'b1;
            DONE: begin
                busy     = 1'b0;
                cfg_done = 1'b1;
            end
            default: ;
        endcase
    end

    assign rd_data = rd_reg;

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Testbench for ccff_chain_loader: a 66-bit / 8-bit instance driven from a
// table of loads against a behavioural chain model, plus a 1-bit chain instance.
module tb_ccff_chain_loader;

    localparam int L = 66;
    localparam int W = 8;
    localparam int NWORDS = (L + W - 1) / W;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic prog_reset, start, bs_valid, bs_ready, rd_valid, rd_ready;
    logic [W-1:0] bs_data, rd_data;
    logic ccff_head, ccff_tail, ccff_shift_en, busy, cfg_done;

    logic s_start, s_bs_valid, s_bs_ready, s_rd_valid, s_rd_ready;
    logic [W-1:0] s_bs_data, s_rd_data;
    logic s_head, s_tail, s_shift_en, s_busy, s_cfg_done;

    ccff_chain_loader #(.CHAIN_LEN(L), .WORD_W(W)) dut (
        .prog_clk(clk), .prog_reset(prog_reset), .start(start),
        .bs_valid(bs_valid), .bs_ready(bs_ready), .bs_data(bs_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
        .ccff_head(ccff_head), .ccff_tail(ccff_tail), .ccff_shift_en(ccff_shift_en),
        .busy(busy), .cfg_done(cfg_done)
    );

    ccff_chain_loader #(.CHAIN_LEN(1), .WORD_W(W)) dut_small (
        .prog_clk(clk), .prog_reset(prog_reset), .start(s_start),
        .bs_valid(s_bs_valid), .bs_ready(s_bs_ready), .bs_data(s_bs_data),
        .rd_valid(s_rd_valid), .rd_ready(s_rd_ready), .rd_data(s_rd_data),
        .ccff_head(s_head), .ccff_tail(s_tail), .ccff_shift_en(s_shift_en),
        .busy(s_busy), .cfg_done(s_cfg_done)
    );

    // Behavioural configuration chains: chain_m[0] at the head, chain_m[L-1] at the tail.
    logic [L-1:0] chain_m = '0;
    logic         chain1  = 1'b1;
    always @(posedge clk) if (ccff_shift_en) chain_m <= {chain_m[L-2:0], ccff_head};
    always @(posedge clk) if (s_shift_en) chain1 <= s_head;
    assign ccff_tail = chain_m[L-1];
    assign s_tail    = chain1;

    typedef struct {
        logic [7:0] word;
        bit         rnd;
        int         rd_stall;
        int         abort_at;
        int         start_at;
        bit         chk_rd;
        logic [7:0] exp_first;
        logic [7:0] exp_last;
    } load_vec_t;

    load_vec_t  vecs[6];
    int         passed = 0;
    int         total  = 0;
    logic [7:0] exp_q[$];
    logic [L-1:0] prev_bits = '0;   // stream bit k of the previous load
    bit         prev_known = 1'b1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [7:0] exp_word(input int j);
        logic [7:0] v = '0;
        for (int b = 0; b < W; b++) if (j * W + b < L) v[b] = prev_bits[j * W + b];
        return v;
    endfunction

    task automatic run_load(input int n, input load_vec_t v);
        int cyc = 0, stall = 0, shift_cnt = 0, head_err = 0, excl_err = 0;
        int bs_words = 0, rd_words = 0;
        bit finished = 0, aborted = 0, start_sent = 0;
        logic [7:0] first_rd = 'x, last_rd = 'x, got;
        logic [L-1:0] exp_chain;
        exp_q.delete();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        while (cyc < 3000) begin
            start = 1'b0;
            if (!busy && cfg_done) begin finished = 1; break; end
            if (ccff_shift_en) begin
                if (ccff_head !== v.word[shift_cnt % W]) head_err++;
                if (bs_ready || rd_valid) excl_err++;
                shift_cnt++;
                if (!start_sent && v.start_at >= 0 && shift_cnt == v.start_at) begin
                    start = 1'b1;
                    start_sent = 1;
                end
            end else if (ccff_head !== 1'b0) excl_err++;
            if (v.abort_at >= 0 && shift_cnt == v.abort_at) begin
                bs_valid = 1'b0; rd_ready = 1'b0;
                @(negedge clk); prog_reset = 1'b0;
                @(negedge clk);
                check($sformatf("load%0d_reset_outputs", n),
                      {busy, cfg_done, bs_ready, rd_valid, ccff_shift_en, ccff_head, rd_data}, '0);
                prog_reset = 1'b1;
                @(negedge clk);
                check($sformatf("load%0d_idle_after_reset", n), {busy, cfg_done, ccff_shift_en}, '0);
                aborted = 1;
                break;
            end
            bs_valid = v.rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            bs_data  = v.word;
            if (bs_ready && bs_valid) begin
                exp_q.push_back(exp_word(bs_words));
                bs_words++;
            end
            if (rd_valid) begin
                if (stall < v.rd_stall) begin
                    rd_ready = 1'b0;
                    stall++;
                end else begin
                    rd_ready = 1'b1;
                    stall = 0;
                    got = rd_data;
                    if (rd_words == 0) first_rd = got;
                    last_rd = got;
                    if (exp_q.size() == 0) check($sformatf("load%0d_rd_unexpected", n), 1, 0);
                    else if (v.chk_rd) check($sformatf("load%0d_rd_word%0d", n, rd_words), got, exp_q.pop_front());
                    else void'(exp_q.pop_front());
                    rd_words++;
                end
            end else rd_ready = 1'b0;
            @(negedge clk);
            cyc++;
        end
        bs_valid = 1'b0; rd_ready = 1'b0;
        if (aborted) begin
            prev_known = 1'b0;
            return;
        end
        check($sformatf("load%0d_finished", n), finished, 1);
        check($sformatf("load%0d_shift_count", n), shift_cnt, L);
        check($sformatf("load%0d_head_errors", n), head_err, 0);
        check($sformatf("load%0d_quiet_errors", n), excl_err, 0);
        check($sformatf("load%0d_bs_words", n), bs_words, NWORDS);
        check($sformatf("load%0d_rd_words", n), rd_words, NWORDS);
        for (int k = 0; k < L; k++) exp_chain[L-1-k] = v.word[k % W];
        check($sformatf("load%0d_chain", n), chain_m, exp_chain);
        if (v.chk_rd) begin
            check($sformatf("load%0d_first_rd", n), first_rd, v.exp_first);
            check($sformatf("load%0d_last_rd", n), last_rd, v.exp_last);
        end
        repeat (4) @(negedge clk);
        check($sformatf("load%0d_stays_done", n), {busy, cfg_done, ccff_shift_en}, 3'b010);
        for (int k = 0; k < L; k++) prev_bits[k] = v.word[k % W];
        prev_known = 1'b1;
    endtask

    task automatic small_load(input int n, input logic [7:0] w, input logic [7:0] exp_rd, input logic exp_ch);
        int cyc = 0, cnt = 0, rd_n = 0;
        bit finished = 0;
        logic [7:0] got = 'x;
        @(negedge clk); s_start = 1'b1;
        @(negedge clk); s_start = 1'b0;
        while (cyc < 50) begin
            if (!s_busy && s_cfg_done) begin finished = 1; break; end
            if (s_shift_en) cnt++;
            s_bs_valid = 1'b1;
            s_bs_data  = w;
            if (s_rd_valid) begin s_rd_ready = 1'b1; got = s_rd_data; rd_n++; end
            else s_rd_ready = 1'b0;
            @(negedge clk);
            cyc++;
        end
        s_bs_valid = 1'b0; s_rd_ready = 1'b0;
        check($sformatf("small%0d_finished", n), finished, 1);
        check($sformatf("small%0d_shift_count", n), cnt, 1);
        check($sformatf("small%0d_rd_words", n), rd_n, 1);
        check($sformatf("small%0d_rd_data", n), got, exp_rd);
        check($sformatf("small%0d_chain", n), chain1, exp_ch);
    endtask

    initial begin
        vecs[0] = '{word: 8'hA5, rnd: 0, rd_stall: 0, abort_at: -1, start_at: -1, chk_rd: 1, exp_first: 8'h00, exp_last: 8'h00};
        vecs[1] = '{word: 8'h3C, rnd: 0, rd_stall: 0, abort_at: -1, start_at: -1, chk_rd: 1, exp_first: 8'hA5, exp_last: 8'h01};
        vecs[2] = '{word: 8'h3C, rnd: 1, rd_stall: 5, abort_at: -1, start_at: -1, chk_rd: 1, exp_first: 8'h3C, exp_last: 8'h00};
        vecs[3] = '{word: 8'h5A, rnd: 0, rd_stall: 0, abort_at: 20, start_at: -1, chk_rd: 1, exp_first: 8'h3C, exp_last: 8'h3C};
        vecs[4] = '{word: 8'hC3, rnd: 0, rd_stall: 0, abort_at: -1, start_at: -1, chk_rd: 0, exp_first: 8'h00, exp_last: 8'h00};
        vecs[5] = '{word: 8'h69, rnd: 0, rd_stall: 2, abort_at: -1, start_at: 10, chk_rd: 1, exp_first: 8'hC3, exp_last: 8'h03};

        prog_reset = 1'b0; start = 1'b0; bs_valid = 1'b0; rd_ready = 1'b0; bs_data = '0;
        s_start = 1'b0; s_bs_valid = 1'b0; s_rd_ready = 1'b0; s_bs_data = '0;
        repeat (3) @(negedge clk);
        check("reset_outputs",
              {busy, cfg_done, bs_ready, rd_valid, ccff_shift_en, ccff_head, rd_data}, '0);
        check("small_reset_outputs",
              {s_busy, s_cfg_done, s_bs_ready, s_rd_valid, s_shift_en, s_head, s_rd_data}, '0);
        prog_reset = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 6; i++) run_load(i, vecs[i]);

        small_load(0, 8'hFF, 8'h01, 1'b1);
        small_load(1, 8'hFE, 8'h01, 1'b0);
        small_load(2, 8'h01, 8'h00, 1'b1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
